up_counter_ctrl: RTL

UP_COUNTER_CTRL -- requirements
Module: up_counter_ctrl

---
 rtl/up_counter_pkg.sv | 5 +
 rtl/up_counter_ctrl_if.sv | 21 ++
 rtl/up_counter_core.sv | 18 +
 rtl/up_counter_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/up_counter_pkg.sv
// up_counter_pkg: FSM state encoding and default width for the up-counter controller
package up_counter_pkg;
  localparam int DEFAULT_WIDTH = 3;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;
endpackage

// File: rtl/up_counter_ctrl_if.sv
// up_counter_ctrl_if: control inputs and status outputs of the up-counter controller
interface up_counter_ctrl_if #(parameter int WIDTH = up_counter_pkg::DEFAULT_WIDTH);
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;
  modport master (
    output start, stop, pause, auto_reload, load_val, term_val,
    input  count, busy, done, wrap
  );
  modport slave (
    input  start, stop, pause, auto_reload, load_val, term_val,
    output count, busy, done, wrap
  );
endinterface

// File: rtl/up_counter_core.sv
// up_counter_core: count register with synchronous load and increment enable
module up_counter_core import up_counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i : en_i ? count_q + WIDTH'(1) : count_q;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl: run/hold/done FSM with captured load/terminal values driving up_counter_core
module up_counter_ctrl import up_counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  up_counter_ctrl_if.slave   ctrl_if
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] load_q, load_d, term_q, term_d, ld_val, count;
  logic             done_q, done_d, wrap_q, wrap_d, ld, en;
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    term_d  = term_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    ld      = 1'b0;
    ld_val  = load_q;
    en      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && ctrl_if.stop) state_d = IDLE;
        else if (ctrl_if.start) begin
          load_d  = ctrl_if.load_val;
          term_d  = ctrl_if.term_val;
          ld      = 1'b1;
          ld_val  = ctrl_if.load_val;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ctrl_if.stop) state_d = IDLE;
        else if (ctrl_if.pause) state_d = HOLD;
        else if (count == term_q) begin
          done_d = 1'b1;
          if (ctrl_if.auto_reload) ld = 1'b1;
          else state_d = DONE;
        end else begin
          en     = 1'b1;
          wrap_d = &count;
        end
      end
      HOLD: begin
        if (ctrl_if.stop) state_d = IDLE;
        else if (!ctrl_if.pause) state_d = RUN;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= '0;
      term_q  <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      term_q  <= term_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end
  up_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .en_i       (en),
    .load_val_i (ld_val),
    .count_o    (count)
  );
  assign ctrl_if.count = count;
  assign ctrl_if.busy  = (state_q == RUN) || (state_q == HOLD);
  assign ctrl_if.done  = done_q;
  assign ctrl_if.wrap  = wrap_q;
endmodule
